// File: rtl/rewind_ctrl.sv
// rewind_ctrl: walks the ROB from the tail back to a mispredicted branch.
// The walk runs youngest entry first and undoes one entry per cycle. For
// each entry it restores the old map-table mapping and returns the newly
// allocated physical register to the free list. When the walk is done it
// rewinds the ROB tail to the entry just after the branch.
// Optional feature (macro REWIND_STATS_EN): a 16-bit saturating counter of
// undone entries, exported as stat_squashed.
module rewind_ctrl #(
  parameter int SIZE      = 32,
  parameter int PHY_BITS  = 6,
  parameter int ROB_DEPTH = 32,
  localparam int IW       = $clog2(ROB_DEPTH),
  localparam int AW       = $clog2(SIZE)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush_valid,
  output logic                flush_ready,
  input  logic [IW-1:0]       flush_idx,
  input  logic [IW-1:0]       rob_tail,
  output logic [IW-1:0]       rd_idx,
  input  logic                rd_has_dst,
  input  logic [AW-1:0]       rd_arc_dst,
  input  logic [PHY_BITS-1:0] rd_phy_old,
  input  logic [PHY_BITS-1:0] rd_phy_new,
  output logic                mt_wr_en,
  output logic [AW-1:0]       mt_wr_arc,
  output logic [PHY_BITS-1:0] mt_wr_phy,
  output logic                fl_ret_en,
  output logic [PHY_BITS-1:0] fl_ret_phy,
  output logic                rename_stall,
  output logic                tail_wr_en,
  output logic [IW-1:0]       tail_wr_idx,
`ifdef REWIND_STATS_EN
  output logic [15:0]         stat_squashed,
`endif
  output logic                done
);

  typedef enum logic [1:0] {IDLE, WALK, FIN} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] cursor, cursor_nxt;
  logic [IW-1:0] count, count_nxt;
  logic [IW-1:0] target, target_nxt;

  // State and walk bookkeeping registers; reset abandons any walk in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cursor <= '0;
      count  <= '0;
      target <= '0;
    end else begin
      state  <= state_nxt;
      cursor <= cursor_nxt;
      count  <= count_nxt;
      target <= target_nxt;
    end
  end

  // Next-state logic and outputs. The restore data simply follows the ROB
  // read port; only the enables qualify it.
  always_comb begin
    state_nxt    = state;
    cursor_nxt   = cursor;
    count_nxt    = count;
    target_nxt   = target;
    flush_ready  = 1'b0;
    rename_stall = 1'b0;
    mt_wr_en     = 1'b0;
    fl_ret_en    = 1'b0;
    tail_wr_en   = 1'b0;
    done         = 1'b0;
    rd_idx       = cursor;
    mt_wr_arc    = rd_arc_dst;
    mt_wr_phy    = rd_phy_old;
    fl_ret_phy   = rd_phy_new;
    tail_wr_idx  = target;
    unique case (state)
      IDLE: begin
        flush_ready = 1'b1;
        if (flush_valid) begin
          // Stall rename in the accept cycle too, so nothing allocates
          // behind the tail that is about to be rewound.
          rename_stall = 1'b1;
          cursor_nxt   = rob_tail - IW'(1);
          count_nxt    = rob_tail - flush_idx - IW'(1);
          target_nxt   = flush_idx + IW'(1);
          state_nxt    = (count_nxt == '0) ? FIN : WALK;
        end
      end
      WALK: begin
        rename_stall = 1'b1;
        mt_wr_en     = rd_has_dst;
        fl_ret_en    = rd_has_dst;
        cursor_nxt   = cursor - IW'(1);
        count_nxt    = count - IW'(1);
        if (count == IW'(1)) state_nxt = FIN;
      end
      FIN: begin
        rename_stall = 1'b1;
        done         = 1'b1;
        tail_wr_en   = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // While reset is held, keep rename_stall low even if a request is
    // already pending.
    if (reset) rename_stall = 1'b0;
  end

`ifdef REWIND_STATS_EN
  // Saturating count of entries undone: one per WALK cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_squashed <= '0;
    end else if (state == WALK && stat_squashed != 16'hFFFF) begin
      stat_squashed <= stat_squashed + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rewind_ctrl.sv
// tb_rewind_ctrl: table of flush requests plus hand-written corner sequences.
// Expected per-cycle walk records go into a scoreboard queue when a flush is
// driven, and are popped and compared cycle by cycle while the DUT rewinds.
module tb_rewind_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       flush_valid;
  logic       flush_ready;
  logic [4:0] flush_idx;
  logic [4:0] rob_tail;
  logic [4:0] rd_idx;
  logic       rd_has_dst;
  logic [4:0] rd_arc_dst;
  logic [5:0] rd_phy_old;
  logic [5:0] rd_phy_new;
  logic       mt_wr_en;
  logic [4:0] mt_wr_arc;
  logic [5:0] mt_wr_phy;
  logic       fl_ret_en;
  logic [5:0] fl_ret_phy;
  logic       rename_stall;
  logic       tail_wr_en;
  logic [4:0] tail_wr_idx;
  logic       done;
`ifdef REWIND_STATS_EN
  logic [15:0] stat_squashed;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rewind_ctrl #(.SIZE(32), .PHY_BITS(6), .ROB_DEPTH(32)) dut (
    .clock(clock), .reset(reset),
    .flush_valid(flush_valid), .flush_ready(flush_ready),
    .flush_idx(flush_idx), .rob_tail(rob_tail), .rd_idx(rd_idx),
    .rd_has_dst(rd_has_dst), .rd_arc_dst(rd_arc_dst),
    .rd_phy_old(rd_phy_old), .rd_phy_new(rd_phy_new),
    .mt_wr_en(mt_wr_en), .mt_wr_arc(mt_wr_arc), .mt_wr_phy(mt_wr_phy),
    .fl_ret_en(fl_ret_en), .fl_ret_phy(fl_ret_phy),
    .rename_stall(rename_stall), .tail_wr_en(tail_wr_en),
    .tail_wr_idx(tail_wr_idx),
`ifdef REWIND_STATS_EN
    .stat_squashed(stat_squashed),
`endif
    .done(done)
  );

  // ROB contents model: every third entry has no destination register.
  function automatic logic m_has(input logic [4:0] i);
    return (i % 5'd3) != 5'd0;
  endfunction
  function automatic logic [4:0] m_arc(input logic [4:0] i);
    return 5'(i * 5'd7);
  endfunction
  function automatic logic [5:0] m_old(input logic [4:0] i);
    return {1'b0, i} + 6'd10;
  endfunction
  function automatic logic [5:0] m_new(input logic [4:0] i);
    return {1'b0, i} + 6'd40;
  endfunction

  assign rd_has_dst = m_has(rd_idx);
  assign rd_arc_dst = m_arc(rd_idx);
  assign rd_phy_old = m_old(rd_idx);
  assign rd_phy_new = m_new(rd_idx);

  typedef struct {
    bit         fin;
    logic [4:0] idx;
    bit         has;
    logic [4:0] arc;
    logic [5:0] pold;
    logic [5:0] pnew;
    logic [4:0] tgt;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [4:0] fidx;
    logic [4:0] tail;
    int         lat;
    logic [4:0] tgt;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Predict the walk: youngest entry first, down to the one after the branch.
  task automatic push_flush(input logic [4:0] fi, input logic [4:0] tl);
    logic [4:0] c;
    exp_t e;
    c = tl - fi - 5'd1;
    for (int k = 0; k < int'(c); k++) begin
      e.fin  = 1'b0;
      e.idx  = tl - 5'd1 - 5'(k);
      e.has  = m_has(e.idx);
      e.arc  = m_arc(e.idx);
      e.pold = m_old(e.idx);
      e.pnew = m_new(e.idx);
      e.tgt  = 5'd0;
      sbq.push_back(e);
    end
    e.fin  = 1'b1;
    e.idx  = fi;
    e.has  = 1'b0;
    e.arc  = 5'd0;
    e.pold = 6'd0;
    e.pnew = 6'd0;
    e.tgt  = fi + 5'd1;
    sbq.push_back(e);
  endtask

  // Pop and compare one record per cycle. In "second" mode a new request is
  // held on the inputs during the walk and must not be accepted.
  task automatic drain(input int lat, input logic [4:0] tgt, input bit second);
    exp_t e;
    int n;
    n = 0;
    while (sbq.size() > 0) begin
      @(negedge clock);
      n++;
      e = sbq.pop_front();
      chk("rd_idx", int'(rd_idx), int'(e.idx));
      chk("rename_stall", int'(rename_stall), 1);
      chk("done", int'(done), int'(e.fin));
      chk("tail_wr_en", int'(tail_wr_en), int'(e.fin));
      chk("mt_wr_en", int'(mt_wr_en), e.fin ? 0 : int'(e.has));
      chk("fl_ret_en", int'(fl_ret_en), e.fin ? 0 : int'(e.has));
      if (!e.fin && e.has) begin
        chk("mt_wr_arc", int'(mt_wr_arc), int'(e.arc));
        chk("mt_wr_phy", int'(mt_wr_phy), int'(e.pold));
        chk("fl_ret_phy", int'(fl_ret_phy), int'(e.pnew));
      end
      if (e.fin) begin
        chk("tail_wr_idx", int'(tail_wr_idx), int'(e.tgt));
        chk("tail_wr_idx_tab", int'(tail_wr_idx), int'(tgt));
        chk("latency", n, lat);
      end
      if (second) chk("flush_ready_busy", int'(flush_ready), 0);
      if (n == 1) begin
        if (second) begin
          flush_idx = 5'd0;
          rob_tail  = 5'd3;
        end else begin
          flush_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_check();
    @(negedge clock);
    chk("idle_ready", int'(flush_ready), 1);
    chk("idle_stall", int'(rename_stall), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_mt_wr_en", int'(mt_wr_en), 0);
    chk("idle_tail_wr_en", int'(tail_wr_en), 0);
  endtask

  task automatic start_flush(input logic [4:0] fi, input logic [4:0] tl);
    @(negedge clock);
    flush_idx   = fi;
    rob_tail    = tl;
    flush_valid = 1'b1;
    #1;
    chk("accept_ready", int'(flush_ready), 1);
    chk("accept_stall", int'(rename_stall), 1);
    push_flush(fi, tl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{fidx: 5'd5,  tail: 5'd9,  lat: 4,  tgt: 5'd6};
    vecs[1] = '{fidx: 5'd30, tail: 5'd2,  lat: 4,  tgt: 5'd31};
    vecs[2] = '{fidx: 5'd4,  tail: 5'd5,  lat: 1,  tgt: 5'd5};
    vecs[3] = '{fidx: 5'd10, tail: 5'd10, lat: 32, tgt: 5'd11};
    vecs[4] = '{fidx: 5'd0,  tail: 5'd20, lat: 20, tgt: 5'd1};
    vecs[5] = '{fidx: 5'd31, tail: 5'd0,  lat: 1,  tgt: 5'd0};

    reset       = 1'b1;
    flush_valid = 1'b0;
    flush_idx   = 5'd0;
    rob_tail    = 5'd0;
    repeat (2) @(negedge clock);
    chk("rst_rd_idx", int'(rd_idx), 0);
    chk("rst_stall", int'(rename_stall), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_mt_wr_en", int'(mt_wr_en), 0);
    chk("rst_fl_ret_en", int'(fl_ret_en), 0);
    chk("rst_tail_wr_en", int'(tail_wr_en), 0);
`ifdef REWIND_STATS_EN
    chk("rst_stat", int'(stat_squashed), 0);
`endif
    reset = 1'b0;
    idle_check();

    for (int v = 0; v < 6; v++) begin
      start_flush(vecs[v].fidx, vecs[v].tail);
      drain(vecs[v].lat, vecs[v].tgt, 1'b0);
      idle_check();
    end
`ifdef REWIND_STATS_EN
    chk("stat_total", int'(stat_squashed), 3 + 3 + 0 + 31 + 19 + 0);
`endif

    // A second request held during a walk waits for the first IDLE cycle.
    start_flush(5'd5, 5'd9);
    drain(4, 5'd6, 1'b1);
    @(negedge clock);
    chk("second_ready", int'(flush_ready), 1);
    chk("second_stall", int'(rename_stall), 1);
    push_flush(5'd0, 5'd3);
    drain(3, 5'd1, 1'b0);
    idle_check();

    // Reset in the second WALK cycle drops everything at once.
    start_flush(5'd0, 5'd20);
    @(negedge clock);
    flush_valid = 1'b0;
    @(negedge clock);
    chk("walk2_rd_idx", int'(rd_idx), 18);
    sbq.delete();
    reset = 1'b1;
    #1;
    chk("mid_rst_mt_wr_en", int'(mt_wr_en), 0);
    chk("mid_rst_fl_ret_en", int'(fl_ret_en), 0);
    chk("mid_rst_stall", int'(rename_stall), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_rd_idx", int'(rd_idx), 0);
`ifdef REWIND_STATS_EN
    chk("mid_rst_stat", int'(stat_squashed), 0);
`endif
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle_check();
    chk("post_rst_rd_idx", int'(rd_idx), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rewind_ctrl.md
REWIND_CTRL -- requirements
Module: rewind_ctrl

Interface
REQ-001 Parameters:
- SIZE, 32: architectural register count.
- PHY_BITS, 6: physical register index width.
- ROB_DEPTH, 32: ROB entries, power of two; IW = log2(ROB_DEPTH).
REQ-002 Ports, one per line as name, direction, width, meaning:
- clock  in  1  single clock; all state SHALL update on its rising edge.
- reset  in  1  asynchronous, active-high.
- flush_valid  in  1  rewind request.
- flush_ready  out  1  request accepted when high with flush_valid.
- flush_idx  in  IW  ROB index of mispredicted branch; the branch survives.
- rob_tail  in  IW  current ROB tail (next free slot), sampled with flush.
- rd_idx  out  IW  ROB read index (combinational read).
- rd_has_dst  in  1  entry at rd_idx writes a register.
- rd_arc_dst  in  log2(SIZE)  architectural destination.
- rd_phy_old  in  PHY_BITS  previous mapping.
- rd_phy_new  in  PHY_BITS  mapping allocated by the entry.
- mt_wr_en  out  1  map-table restore write.
- mt_wr_arc  out  log2(SIZE)  restore address.
- mt_wr_phy  out  PHY_BITS  restore value.
- fl_ret_en  out  1  return a register to the free list.
- fl_ret_phy  out  PHY_BITS  register returned.
- rename_stall  out  1  blocks rename and ROB allocation.
- tail_wr_en  out  1  one-cycle ROB tail update.
- tail_wr_idx  out  IW  new tail.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 FSM states IDLE, WALK, FIN; flush_ready SHALL be high only in IDLE.
REQ-004 On flush_valid&&flush_ready: register cursor=(rob_tail-1) mod ROB_DEPTH, count=(rob_tail-flush_idx-1) mod ROB_DEPTH, target=(flush_idx+1) mod ROB_DEPTH.
REQ-005 IDLE->WALK when count!=0; IDLE->FIN when count==0.
REQ-006 In WALK, each cycle: rd_idx=cursor; if rd_has_dst then mt_wr_en=1, mt_wr_arc=rd_arc_dst, mt_wr_phy=rd_phy_old, fl_ret_en=1, fl_ret_phy=rd_phy_new; else both enables low.
REQ-007 In WALK, each cycle: cursor decrements with wrap (0->ROB_DEPTH-1) and count decrements; WALK->FIN in the cycle count==1 is processed.
REQ-008 Exactly one entry SHALL be undone per WALK cycle, youngest first; latency from accept to done = count+1 cycles.
REQ-009 FIN lasts one cycle: done=1, tail_wr_en=1, tail_wr_idx=target; FIN->IDLE.
REQ-010 rename_stall SHALL be high in WALK and FIN and in the accept cycle (combinationally from flush_valid in IDLE).
REQ-011 flush_valid in WALK/FIN SHALL be ignored (not accepted, no state change); the requester holds it.
REQ-012 mt_wr_en, fl_ret_en, tail_wr_en and done SHALL be low in IDLE; rd_idx SHALL equal cursor in all states.
REQ-013 All index arithmetic SHALL be modulo ROB_DEPTH; flush_idx==rob_tail-1 yields an empty walk; the full-ROB case flush_idx==rob_tail yields count=ROB_DEPTH-1.

Reset
REQ-014 reset SHALL asynchronously force IDLE, cursor=0, count=0, target=0 and all enables, done and rename_stall low, including mid-WALK; no partial restore continues after release.

Configuration
REQ-015 Macro REWIND_STATS_EN: when defined, add output stat_squashed (16 bits), a saturating count of entries undone, incremented once per WALK cycle and cleared by reset.
REQ-016 Without REWIND_STATS_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-017 flush_idx=5, rob_tail=9 -> 3 WALK cycles with rd_idx 8,7,6, then done with tail_wr_idx=6; accept to done is 4 cycles.
REQ-018 Wrap case: flush_idx=30, rob_tail=2 -> rd_idx 1,0,31, then tail_wr_idx=31.
REQ-019 flush_idx=4, rob_tail=5 -> FIN the next cycle, no mt_wr_en, tail_wr_idx=5.
REQ-020 An entry with rd_has_dst=0 mid-walk -> that cycle has mt_wr_en=0 and fl_ret_en=0 while cursor still decrements.
REQ-021 A second flush_valid during WALK -> flush_ready=0, walk unaffected; accepted in the first IDLE cycle after done.
REQ-022 reset asserted in the 2nd WALK cycle -> outputs low immediately, IDLE and flush_ready=1 after release; with REWIND_STATS_EN, stat_squashed=0.
